// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the single-port word memory and its request
// controller: controller state encoding, address width and the default
// memory geometry used by both `memory` and mem_req_ctrl.
// ---------------------------------------------------------------------------
package mem_pkg;

  // Word address width of the memory.
  localparam int ADDR_W = 4;

  // Default data MSB index (data width is MEM_W_DEF+1) and depth in words.
  localparam int MEM_W_DEF = 7;
  localparam int MEM_L_DEF = 10;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    RSP  = 2'd3
  } state_t;

endpackage

// File: rtl/memory.sv
// ---------------------------------------------------------------------------
// memory
// Small single-port word memory with one clock edge of read latency.
// Ports:
//   clk      - rising-edge clock
//   enable   - access strobe; nothing happens while low
//   wrt_read - 1 = write `write` to `add`, 0 = read `add` into `out`
//   add      - word address; writes at or beyond depth l are dropped
//   write    - write data (w+1 bits)
//   out      - registered read data (w+1 bits)
// ---------------------------------------------------------------------------
module memory
  import mem_pkg::*;
#(
  parameter int w = MEM_W_DEF,
  parameter int l = MEM_L_DEF
) (
  input  logic              clk,
  input  logic              enable,
  input  logic              wrt_read,
  input  logic [ADDR_W-1:0] add,
  input  logic [w:0]        write,
  output logic [w:0]        out
);

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W + 1)'(l);

  // Storage covers the full address space so any address can be indexed;
  // only the first l words are ever written.
  logic [w:0] r_mem [2**ADDR_W];

  // Writes land on the edge that ends the enable cycle; reads register the
  // addressed word into out on that same edge.
  always_ff @(posedge clk) begin
    if (enable) begin
      if (wrt_read) begin
        if ({1'b0, add} < DEPTH) begin
          r_mem[add] <= write;
        end
      end else begin
        out <= r_mem[add];
      end
    end
  end

endmodule

// File: rtl/mem_req_ctrl.sv
// ---------------------------------------------------------------------------
// mem_req_ctrl
// Upstream request controller for the single-port word memory. Accepts one
// read or write request at a time over a valid/ready handshake, drives the
// memory pins from registers, waits the read latency, and returns a response
// held until the client takes it. Out-of-range addresses are answered with an
// error without touching the memory.
// Ports:
//   clk, reset                 - rising-edge clock, async active-low reset
//   req_valid/req_ready        - request handshake
//   req_wr, req_addr, req_data - request kind (1 = write), address, data
//   rsp_valid/rsp_ready        - response handshake
//   rsp_data, rsp_err          - read data (0 for writes/errors), range error
//   mem_enable, mem_wrt_read,
//   mem_add, mem_write         - registered drives to the memory
//   mem_out                    - read data from the memory
// ---------------------------------------------------------------------------
module mem_req_ctrl
  import mem_pkg::*;
#(
  parameter int W      = MEM_W_DEF,
  parameter int L      = MEM_L_DEF,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [W:0]        req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [W:0]        rsp_data,
  output logic              rsp_err,
  output logic              mem_enable,
  output logic              mem_wrt_read,
  output logic [ADDR_W-1:0] mem_add,
  output logic [W:0]        mem_write,
  input  logic [W:0]        mem_out
);

  localparam logic [ADDR_W:0] ADDR_LIM = (ADDR_W + 1)'(L);
  localparam logic [1:0]      LAT_CNT  = 2'(RD_LAT);

  state_t            r_state;
  state_t            w_nextState;
  logic [1:0]        r_cnt;
  logic [1:0]        w_cntNext;
  logic              r_reqReady;
  logic              r_rspValid;
  logic              w_rspValidNext;
  logic [W:0]        r_rspData;
  logic [W:0]        w_rspDataNext;
  logic              r_rspErr;
  logic              w_rspErrNext;
  logic              r_memEn;
  logic              w_memEnNext;
  logic              r_memWr;
  logic              w_memWrNext;
  logic [ADDR_W-1:0] r_memAdd;
  logic [ADDR_W-1:0] w_memAddNext;
  logic [W:0]        r_memWrite;
  logic [W:0]        w_memWriteNext;

  logic w_accept;
  logic w_addrBad;
  logic w_latDone;

  assign w_accept  = req_valid && r_reqReady;
  assign w_addrBad = ({1'b0, req_addr} >= ADDR_LIM);
  assign w_latDone = (r_cnt == LAT_CNT);

  // State and output registers. Reset clears everything, including the
  // memory enable, so an in-flight access is dropped on the spot. req_ready
  // is registered from the next state so it stays low during reset and rises
  // on the first edge after release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_cnt      <= 2'd0;
      r_reqReady <= 1'b0;
      r_rspValid <= 1'b0;
      r_rspData  <= '0;
      r_rspErr   <= 1'b0;
      r_memEn    <= 1'b0;
      r_memWr    <= 1'b0;
      r_memAdd   <= '0;
      r_memWrite <= '0;
    end else begin
      r_state    <= w_nextState;
      r_cnt      <= w_cntNext;
      r_reqReady <= (w_nextState == IDLE);
      r_rspValid <= w_rspValidNext;
      r_rspData  <= w_rspDataNext;
      r_rspErr   <= w_rspErrNext;
      r_memEn    <= w_memEnNext;
      r_memWr    <= w_memWrNext;
      r_memAdd   <= w_memAddNext;
      r_memWrite <= w_memWriteNext;
    end
  end

  // Next-state decode. A write spends exactly one cycle in WR; a read stays
  // in RD until the latency counter reaches RD_LAT; errors skip straight to
  // RSP. RSP only returns to IDLE once the client takes the response.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_addrBad) begin
            w_nextState = RSP;
          end else if (req_wr) begin
            w_nextState = WR;
          end else begin
            w_nextState = RD;
          end
        end
      end
      WR:      w_nextState = RSP;
      RD:      if (w_latDone) w_nextState = RSP;
      RSP:     if (rsp_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Next values of the registered outputs. Everything holds by default, so
  // the memory pins and the response stay put outside the transitions that
  // explicitly change them. req_data is only loaded for writes.
  always_comb begin
    w_cntNext      = r_cnt;
    w_rspValidNext = r_rspValid;
    w_rspDataNext  = r_rspData;
    w_rspErrNext   = r_rspErr;
    w_memEnNext    = r_memEn;
    w_memWrNext    = r_memWr;
    w_memAddNext   = r_memAdd;
    w_memWriteNext = r_memWrite;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_addrBad) begin
            w_rspValidNext = 1'b1;
            w_rspErrNext   = 1'b1;
            w_rspDataNext  = '0;
          end else if (req_wr) begin
            w_memAddNext   = req_addr;
            w_memWriteNext = req_data;
            w_memWrNext    = 1'b1;
            w_memEnNext    = 1'b1;
          end else begin
            w_memAddNext = req_addr;
            w_memWrNext  = 1'b0;
            w_memEnNext  = 1'b1;
            w_cntNext    = 2'd0;
          end
        end
      end
      WR: begin
        w_memEnNext    = 1'b0;
        w_rspValidNext = 1'b1;
        w_rspErrNext   = 1'b0;
        w_rspDataNext  = '0;
      end
      RD: begin
        w_cntNext = r_cnt + 2'd1;
        if (w_latDone) begin
          w_rspDataNext  = mem_out;
          w_rspValidNext = 1'b1;
          w_rspErrNext   = 1'b0;
          w_memEnNext    = 1'b0;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          w_rspValidNext = 1'b0;
        end
      end
      default: begin
      end
    endcase
  end

  assign req_ready    = r_reqReady;
  assign rsp_valid    = r_rspValid;
  assign rsp_data     = r_rspData;
  assign rsp_err      = r_rspErr;
  assign mem_enable   = r_memEn;
  assign mem_wrt_read = r_memWr;
  assign mem_add      = r_memAdd;
  assign mem_write    = r_memWrite;

endmodule

// File: doc/mem_req_ctrl.md
Name: mem_req_ctrl

Overview:
- Upstream request controller for the small single-port word memory (`memory`, parameters `w`/`l`, 4-bit address).
- Accepts read/write requests from a client over a valid/ready handshake and drives the memory's `enable`/`wrt_read`/`add`/`write` pins from registers.
- Waits a fixed read latency, captures the memory `out`, and returns a response with valid/ready backpressure.
- Rejects out-of-range addresses (addr >= L) without touching the memory.

Parameters:
- W, 7, data MSB index; data width is W+1 (matches memory `w`).
- L, 10, memory depth in words; legal addresses 0..L-1 (matches memory `l`).
- RD_LAT, 1, clock edges from memory inputs stable to `out` valid; legal range 0..3.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  client request present.
- req_ready  out  1  controller can accept a request.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  4  word address.
- req_data  in  W+1  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  client accepts response.
- rsp_data  out  W+1  read data; 0 for writes and errors.
- rsp_err  out  1  address was out of range.
- mem_enable  out  1  to memory `enable`.
- mem_wrt_read  out  1  to memory `wrt_read` (1 = write).
- mem_add  out  4  to memory `add`.
- mem_write  out  W+1  to memory `write`.
- mem_out  in  W+1  from memory `out`.

Behaviour:
- Reset (reset = 0, asynchronous, any state):
  - state goes to IDLE.
  - All outputs go to 0, except req_ready, which goes to 1 after reset releases.
  - mem_enable drops immediately; an in-flight read or write is abandoned and produces no response.
- All outputs are registered. req_ready is a decode of state == IDLE.
- States: IDLE, WR, RD, RSP.
- IDLE:
  - req_ready = 1. Accept on the edge where req_valid && req_ready.
  - If req_addr >= L: go to RSP with rsp_err = 1 and rsp_data = 0. mem_enable stays 0.
  - Else if req_wr = 1: load mem_add = req_addr, mem_write = req_data, mem_wrt_read = 1, mem_enable = 1. Go to WR.
  - Else: load mem_add = req_addr, mem_wrt_read = 0, mem_enable = 1. Go to RD. Clear the 2-bit latency counter.
- WR:
  - Lasts exactly one cycle; the memory writes on the edge that ends it.
  - On that edge: mem_enable -> 0, rsp_valid -> 1, rsp_err -> 0, rsp_data -> 0. Go to RSP.
  - Write response is valid 2 cycles after acceptance.
- RD:
  - mem_enable, mem_wrt_read and mem_add are held stable.
  - The counter increments each edge.
  - On the edge where counter == RD_LAT: capture rsp_data <= mem_out, rsp_valid -> 1, mem_enable -> 0. Go to RSP.
  - Read response is valid RD_LAT+2 cycles after acceptance (3 cycles at default).
- RSP:
  - rsp_valid, rsp_data and rsp_err are held until rsp_ready = 1.
  - On the edge with rsp_ready: rsp_valid -> 0, go to IDLE.
  - No new request is accepted in the same cycle; at most one transaction is outstanding.
  - Minimum issue interval is therefore 3 cycles for writes and RD_LAT+3 cycles for reads.
- Boundaries:
  - addr = L-1 is legal; addr = L..15 gives an error.
  - req_data is ignored for reads.
  - req_valid deasserting while req_ready = 0 has no effect.
  - rsp_ready held at 1 continuously is legal.
  - mem_* outputs never change while in RSP or IDLE, except for the mem_enable fall described above.

Decomposition:
- Shared package mem_pkg holds:
  - State encoding constants: IDLE = 2'd0, WR = 2'd1, RD = 2'd2, RSP = 2'd3.
  - Address width constant ADDR_W = 4.
  - Default W/L values, shared with `memory`.
- No sub-module is needed: a single FSM plus counter, about 150 lines.
- The bench instantiates mem_req_ctrl together with `memory`, wired through the mem_* ports.

Test Plan:
- Reset asserted at t = 0 -> all outputs 0, rsp_valid = 0. After release -> req_ready = 1.
- Write 10 @0, 33 @3 and 66 @5, with rsp_ready = 1 -> each rsp_valid pulses 2 cycles after acceptance with rsp_err = 0. The memory then holds 10/33/66 at those addresses.
- Read @0, @3 and @5 -> rsp_data = 10, 33, 66 respectively, each 3 cycles after acceptance (RD_LAT = 1), with mem_enable = 1 and mem_wrt_read = 0 during RD.
- Read @12 and write @10 -> rsp_err = 1, rsp_data = 0, mem_enable never asserts, response 1 cycle after acceptance.
- Read @3 with rsp_ready = 0 for 4 cycles -> rsp_valid = 1 and rsp_data = 33 stay stable, req_ready = 0 throughout. Response accepted on the 5th cycle, then req_ready = 1.
- Reset pulsed during RD of @5 -> outputs clear asynchronously (mem_enable = 0 before the next edge), no response is issued, and the next read @0 returns 10.
